fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that produces the `pc`/`instr` stream consumed by the IF/ID pipeline register. It owns the program counter and issues requests on a req/ready instruction-memory interface, at most one outstanding. Fetched words are buffered in a 2-entry queue so that downstream `stall_i` never drops an instruction. Branch/jump redirects flush the queue and retarget the PC, with a drain phase for any in-flight memory request.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `stall_i`  in  1  downstream hold; the head entry is not consumed this cycle.
- `redirect_i`  in  1  taken branch/jump; flush the queue and refetch.
- `redirect_pc_i`  in  32  new fetch address, sampled when `redirect_i`=1.
- `imem_req_o`  out  1  memory request valid.
- `imem_addr_o`  out  32  request address; stable while `imem_req_o`=1 and `imem_ready_i`=0.
- `imem_ready_i`  in  1  request accepted; data returned in the same cycle.
- `imem_rdata_i`  in  32  instruction word, valid when `imem_req_o & imem_ready_i`.
- `valid_o`  out  1  queue head valid.
- `pc_o`  out  32  head PC; 0 when `valid_o`=0.
- `instr_o`  out  32  head instruction; 0 (bubble) when `valid_o`=0.

## Operation
- **State:** `pc_q` (next fetch address), 2-entry queue of {pc, instr} with `count` 0..2, and FSM states IDLE, RUN, DRAIN.
- **Reset values:** state IDLE; `pc_q`=`RESET_PC`; `count`=0; queue contents 0. Therefore `imem_req_o`=0, `imem_addr_o`=`pc_q`, `valid_o`=0, `pc_o`=0, `instr_o`=0.
- **IDLE:** `imem_req_o`=0. Moves to RUN on the next edge. If `redirect_i`=1 in IDLE, `pc_q` <= `redirect_pc_i`.
- **RUN:**
  - `imem_req_o` = (`count` < 2).
  - `imem_addr_o` = `pc_q`.
  - Push occurs on `imem_req_o & imem_ready_i & !redirect_i`: enqueue {`pc_q`, `imem_rdata_i`} and set `pc_q` <= `pc_q`+4.
- **Pop:** occurs on `valid_o & !stall_i & !redirect_i`. Push and pop may happen in the same cycle; `count` is then unchanged.
- **Redirect (priority over push and pop):**
  - `count` <= 0 and `pc_q` <= `redirect_pc_i`.
  - If `imem_req_o`=1 and `imem_ready_i`=0 in that cycle, go to DRAIN.
  - Otherwise stay in RUN; a same-cycle response is discarded.
- **DRAIN:**
  - `imem_req_o`=1 and `imem_addr_o` = the latched stale address.
  - On `imem_ready_i`, discard the data and go to RUN.
  - A further `redirect_i` in DRAIN overwrites `pc_q`; the FSM stays in DRAIN.
  - `valid_o`=0 throughout.
- **Width rule:** `pc_q`+4 wraps modulo 2^32 (`32'hFFFF_FFFC` -> 0). `redirect_pc_i` is used unmodified.
- **Request stability:** `count` only rises via this unit's own pushes, so a request raised with `count`<2 is never withdrawn before `imem_ready_i`.
- **Reset mid-request:** the request is abandoned immediately (`imem_req_o`=0 asynchronously). The memory model must tolerate this.

## Timing
- Latency: `imem_ready_i` in cycle N -> entry visible on `valid_o`/`pc_o`/`instr_o` in cycle N+1.
- Throughput: with a zero-wait memory and `stall_i`=0, one instruction per cycle, and `imem_req_o` stays high continuously.
- Stall: `count` reaches 2 after at most 2 more responses. `imem_req_o` drops the cycle after `count`=2 and rises the cycle after the first pop.
- Redirect: `valid_o`=0 the cycle after `redirect_i`. The first redirected fetch is requested that same cycle in RUN, or the cycle after the drain completes in DRAIN.
- Outputs are registered-state decodes; there is no combinational path from `stall_i` to `imem_req_o`.

## Configuration
- **`FETCH_PERF_CNT_EN` defined:** adds two outputs.
  - `perf_fetch_o[31:0]`: counts pops.
  - `perf_bubble_o[31:0]`: counts cycles with `valid_o`=0 and state != IDLE.
  - Both reset to 0 and wrap at 2^32.
- **Not defined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset and start:** `RESET_PC`=0x100, memory with 0 wait states and `stall_i`=0 -> `imem_req_o` first high in the cycle after IDLE with addr 0x100. `valid_o` pcs read 0x100, 0x104, 0x108 on consecutive cycles with matching `instr_o`.
- **Stall:** assert `stall_i` for 5 cycles mid-stream -> `pc_o`/`instr_o` held, `count`=2, `imem_req_o`=0. After release, the sequence continues with no skipped or duplicated PC.
- **Redirect during wait:** memory latency 3 cycles; assert `redirect_i` to 0x400 one cycle after a request to 0x108 -> `imem_addr_o` stays 0x108 until ready and that data is dropped. The next request is 0x400 and the first valid `pc_o` is 0x400.
- **Redirect same cycle as ready:** redirect to 0x20 together with `imem_ready_i` -> no DRAIN, data dropped, next request addr 0x20.
- **Wrap:** redirect to 0xFFFF_FFFC -> fetched pcs 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-drain:** pull `rst_n_i` low while in DRAIN -> `imem_req_o`=0, `valid_o`=0 and `pc_o`=0 immediately. Restart fetches `RESET_PC`. With `FETCH_PERF_CNT_EN`, both counters read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// buffers responses in a 2-entry queue. FETCH_PERF_CNT_EN adds fetch/bubble counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_bubble_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     pc_q;
    logic [31:0]     stale_q;
    logic [1:0]      count_q;
    entry_t [1:0]    queue_q;
    logic            push, pop, wr_idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (redirect_i && imem_req_o && !imem_ready_i) state_d = DRAIN;
            DRAIN:   if (imem_ready_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // DRAIN keeps presenting the stale address until the in-flight request is accepted.
    always_comb begin
        imem_req_o  = (state_q == DRAIN) || ((state_q == RUN) && !count_q[1]);
        imem_addr_o = (state_q == DRAIN) ? stale_q : pc_q;
        valid_o     = (count_q != 2'd0);
        pc_o        = valid_o ? queue_q[0].pc    : 32'd0;
        instr_o     = valid_o ? queue_q[0].instr : 32'd0;
    end

    assign push   = (state_q == RUN) && imem_req_o && imem_ready_i && !redirect_i;
    assign pop    = valid_o && !stall_i && !redirect_i;
    // Slot behind the head after this cycle's pop: count - pop, which is always 0 or 1 here.
    assign wr_idx = count_q[0] ^ pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q    <= RESET_PC;
            stale_q <= 32'd0;
            count_q <= 2'd0;
            queue_q <= '0;
        end else if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            count_q <= 2'd0;
            if ((state_q == RUN) && imem_req_o && !imem_ready_i) stale_q <= pc_q;
        end else begin
            if (push) pc_q <= pc_q + 32'd4;
            if (push && !pop)      count_q <= count_q + 2'd1;
            else if (pop && !push) count_q <= count_q - 2'd1;
            if (pop)  queue_q[0]      <= queue_q[1];
            if (push) queue_q[wr_idx] <= {pc_q, imem_rdata_i};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetch_o  <= 32'd0;
            perf_bubble_o <= 32'd0;
        end else begin
            if (pop) perf_fetch_o <= perf_fetch_o + 32'd1;
            if (!valid_o && (state_q != IDLE)) perf_bubble_o <= perf_bubble_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based reference model plus directed
// scenarios (start-up, stall, redirect during wait / with ready, wrap, reset in drain).
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_o, perf_bubble_o;
`endif

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch_o), .perf_bubble_o(perf_bubble_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 draining; queue held as two SV queues.
    int          mst;
    logic [31:0] mpc, mstale;
    logic [31:0] qpc[$];
    logic [31:0] qins[$];
    logic [31:0] pop_log[$];
    logic [31:0] mfetch, mbubble;

    // Memory: each accepted request waits lat cycles (0 = same-cycle ready).
    int   wait_cnt, lat, lat_min, lat_max;
    logic rdy;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit m_req();
        return (mst == 1 && qpc.size() < 2) || (mst == 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return (mst == 2) ? mstale : mpc;
    endfunction

    task automatic model_reset();
        mst = 0; mpc = RST_PC; mstale = 32'd0;
        qpc.delete(); qins.delete();
        mfetch = 32'd0; mbubble = 32'd0;
        wait_cnt = 0;
        lat = int'($urandom_range(lat_max, lat_min));
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc, input logic r);
        bit mv, req;
        mv  = qpc.size() > 0;
        req = m_req();
        if (mst != 0 && !mv) mbubble++;
        case (mst)
            0: begin
                if (rd) mpc = rpc;
                mst = 1;
            end
            1: begin
                if (rd) begin
                    if (req && !r) begin mstale = mpc; mst = 2; end
                    qpc.delete(); qins.delete();
                    mpc = rpc;
                end else begin
                    if (mv && !st) begin
                        pop_log.push_back(qpc.pop_front());
                        void'(qins.pop_front());
                        mfetch++;
                    end
                    if (req && r) begin
                        qpc.push_back(mpc);
                        qins.push_back(mem_word(mpc));
                        mpc = mpc + 32'd4;
                    end
                end
            end
            default: begin
                if (rd) mpc = rpc;
                if (r) mst = 1;
            end
        endcase
    endtask

    // Entered at a negedge: compare, drive this cycle's inputs, advance model, wait one cycle.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
        logic rd_eff;
        bit   mv;
        mv = qpc.size() > 0;
        check("req", 32'(imem_req_o), 32'(m_req()));
        if (m_req()) check("addr", imem_addr_o, m_addr());
        check("valid", 32'(valid_o), 32'(mv));
        check("pc", pc_o, mv ? qpc[0] : 32'd0);
        check("instr", instr_o, mv ? qins[0] : 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch_o, mfetch);
        check("perf_bubble", perf_bubble_o, mbubble);
`endif
        rdy    = imem_req_o && (wait_cnt >= lat);
        rd_eff = rd && !(mst == 2 && rdy);
        stall_i       = st;
        redirect_i    = rd_eff;
        redirect_pc_i = rpc;
        imem_ready_i  = rdy;
        imem_rdata_i  = rdy ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
        model_step(st, rd_eff, rpc, rdy);
        if (imem_req_o) begin
            if (rdy) begin wait_cnt = 0; lat = int'($urandom_range(lat_max, lat_min)); end
            else wait_cnt++;
        end else wait_cnt = 0;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        stall_i = 1'b0; redirect_i = 1'b0; imem_ready_i = 1'b0;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch_o, 32'd0);
        check("rst_perf_bubble", perf_bubble_o, 32'd0);
`endif
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  drained;
        logic [31:0] held;
        #2;
        // Start-up with a zero-wait memory.
        lat_min = 0; lat_max = 0;
        do_reset();
        pop_log.delete();
        check("start_idle_req", 32'(imem_req_o), 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check("start_req", 32'(imem_req_o), 32'd1);
        check("start_addr", imem_addr_o, 32'h100);
        cycle(1'b0, 1'b0, 32'd0);
        check("start_pc", pc_o, 32'h100);
        check("start_instr", instr_o, mem_word(32'h100));
        repeat (5) cycle(1'b0, 1'b0, 32'd0);

        // Stall five cycles: head held, queue fills, request drops.
        held = pc_o;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            check("stall_hold", pc_o, held);
        end
        check("stall_req_low", 32'(imem_req_o), 32'd0);
        repeat (8) cycle(1'b0, 1'b0, 32'd0);
        check("seq_len_ok", 32'(pop_log.size() >= 12), 32'd1);
        foreach (pop_log[i]) check("pop_seq", pop_log[i], RST_PC + 32'(4 * i));

        // Redirect one cycle after a request to 0x108 while memory latency is 3.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (n = 0; n < 40 && !(mst == 1 && m_req() && mpc == 32'h108); n++) cycle(1'b0, 1'b0, 32'd0);
        check("found_req_108", 32'(n < 40), 32'd1);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h400);
        check("drain_valid", 32'(valid_o), 32'd0);
        drained = 1'b0;
        for (n = 0; n < 10 && !drained; n++) begin
            check("drain_req", 32'(imem_req_o), 32'd1);
            check("drain_addr", imem_addr_o, 32'h108);
            cycle(1'b0, 1'b0, 32'd0);
            drained = rdy;
        end
        check("drain_done", 32'(drained), 32'd1);
        check("post_drain_req", 32'(imem_req_o), 32'd1);
        check("post_drain_addr", imem_addr_o, 32'h400);
        for (n = 0; n < 10 && !valid_o; n++) cycle(1'b0, 1'b0, 32'd0);
        check("redir_first_pc", pc_o, 32'h400);

        // Redirect in the same cycle as ready: no drain, next request goes to 0x20.
        lat_min = 0; lat_max = 0;
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h20);
        check("sameready_req", 32'(imem_req_o), 32'd1);
        check("sameready_addr", imem_addr_o, 32'h20);
        check("sameready_valid", 32'(valid_o), 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check("sameready_pc", pc_o, 32'h20);
        check("sameready_instr", instr_o, mem_word(32'h20));

        // PC wrap.
        pop_log.delete();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (4) cycle(1'b0, 1'b0, 32'd0);
        check("wrap_len_ok", 32'(pop_log.size() >= 2), 32'd1);
        if (pop_log.size() >= 2) begin
            check("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
            check("wrap_pc1", pop_log[1], 32'h0000_0000);
        end

        // Random traffic.
        lat_min = 0; lat_max = 3;
        do_reset();
        repeat (3000)
            cycle(($urandom() % 4) == 0, ($urandom() % 16) == 0,
                  (($urandom() % 8) == 0) ? $urandom() : {$urandom_range(32'h3FFF, 0), 2'b00});

        // Reset while draining.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (n = 0; n < 30 && mst != 2; n++) begin
            if (mst == 1 && m_req() && wait_cnt < lat) cycle(1'b0, 1'b1, 32'h800);
            else cycle(1'b0, 1'b0, 32'd0);
        end
        check("reached_drain", 32'(mst), 32'd2);
        check("in_drain_req", 32'(imem_req_o), 32'd1);
        #2;
        pop_log.delete();
        do_reset();
        for (n = 0; n < 20 && pop_log.size() == 0; n++) cycle(1'b0, 1'b0, 32'd0);
        check("restart_len_ok", 32'(pop_log.size() >= 1), 32'd1);
        if (pop_log.size() >= 1) check("restart_pc", pop_log[0], RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
